// File: rtl/hash_pkg.sv
// Shared definitions for the hash engine command front-end: op codes, response
// status, issuer states, command payload and the status priority rule.
package hash_pkg;

  localparam int unsigned HASH_KEY_WIDTH  = 2;
  localparam int unsigned HASH_DATA_WIDTH = 32;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  typedef enum logic [2:0] {
    ST_OK            = 3'd0,
    ST_NOT_FOUND     = 3'd1,
    ST_KEY_PRESENT   = 3'd2,
    ST_NO_SPACE      = 3'd3,
    ST_NO_DEL_TARGET = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } issuer_state_e;

  typedef struct packed {
    logic [1:0]                 op;
    logic [HASH_KEY_WIDTH-1:0]  key;
    logic [HASH_DATA_WIDTH-1:0] data;
  } cmd_t;

  // Only the flags relevant to the op can fail it; write checks key_present first.
  function automatic status_e cmd_status(input logic [1:0] op,
                                         input logic no_elem_found,
                                         input logic key_present,
                                         input logic no_write_space,
                                         input logic no_del_target);
    status_e st;
    st = ST_OK;
    case (op)
      OP_READ:   if (no_elem_found) st = ST_NOT_FOUND;
      OP_WRITE:  begin
        if (key_present)         st = ST_KEY_PRESENT;
        else if (no_write_space) st = ST_NO_SPACE;
      end
      OP_DELETE: if (no_del_target) st = ST_NO_DEL_TARGET;
      default:   st = ST_OK;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/hash_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible on rdata_o
// whenever empty_o is low and is consumed by pop_i.
module hash_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hash_cmd_issuer.sv
// Host command front-end: buffers commands and sequences each one into the hash
// table controller as LOOKUP then a single EXEC cycle, returning a response.
module hash_cmd_issuer
  import hash_pkg::*;
#(
  parameter int unsigned KEY_WIDTH      = HASH_KEY_WIDTH,
  parameter int unsigned DATA_WIDTH     = HASH_DATA_WIDTH,
  parameter int unsigned LOOKUP_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [KEY_WIDTH-1:0]  cmd_key_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic [KEY_WIDTH-1:0]  tbl_key_o,
  output logic [DATA_WIDTH-1:0] tbl_data_o,
  output logic [1:0]            tbl_op_o,
  input  logic [DATA_WIDTH-1:0] tbl_read_data_i,
  input  logic                  tbl_no_del_target_i,
  input  logic                  tbl_no_write_space_i,
  input  logic                  tbl_no_elem_found_i,
  input  logic                  tbl_key_present_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [1:0]            resp_op_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [2:0]            resp_status_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  ok_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  localparam int unsigned CMD_W  = $bits(cmd_t);
  localparam int unsigned LCNT_W = (LOOKUP_LATENCY > 1) ? $clog2(LOOKUP_LATENCY) : 1;
  localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOOKUP_LATENCY - 1);

  issuer_state_e         state_q, state_d;
  logic [LCNT_W-1:0]     lcnt_q, lcnt_d;
  cmd_t                  work_q, work_d;
  cmd_t                  push_cmd, head;
  logic [CMD_W-1:0]      head_raw;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]            tbl_op_q, tbl_op_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [1:0]            resp_op_q, resp_op_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  status_e               resp_status_q, resp_status_d, exec_status;
  logic [CNT_WIDTH-1:0]  ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    push_cmd.op   = cmd_op_i;
    push_cmd.key  = HASH_KEY_WIDTH'(cmd_key_i);
    push_cmd.data = HASH_DATA_WIDTH'(cmd_data_i);
  end

  assign fifo_push = cmd_valid_i && !fifo_full;
  assign head      = cmd_t'(head_raw);

  hash_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, response capture and statistics.
  always_comb begin
    state_d       = state_q;
    lcnt_d        = lcnt_q;
    work_d        = work_q;
    fifo_pop      = 1'b0;
    resp_op_d     = resp_op_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    ok_cnt_d      = ok_cnt_q;
    err_cnt_d     = err_cnt_q;
    exec_status   = cmd_status(work_q.op, tbl_no_elem_found_i, tbl_key_present_i,
                               tbl_no_write_space_i, tbl_no_del_target_i);
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.op != OP_NOP) begin
            work_d  = head;
            lcnt_d  = LCNT_INIT;
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (lcnt_q == '0) state_d = S_EXEC;
        else              lcnt_d  = lcnt_q - LCNT_W'(1);
      end
      S_EXEC: begin
        resp_op_d     = work_q.op;
        resp_status_d = exec_status;
        // Read data is only meaningful for a successful read.
        resp_data_d   = ((work_q.op == OP_READ) && (exec_status == ST_OK)) ?
                        tbl_read_data_i : '0;
        if (exec_status == ST_OK) begin
          if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (head.op != OP_NOP) begin
              work_d  = head;
              lcnt_d  = LCNT_INIT;
              state_d = S_LOOKUP;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    tbl_op_d     = (state_d == S_EXEC) ? work_d.op : OP_NOP;
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lcnt_q        <= '0;
      work_q        <= '0;
      tbl_op_q      <= OP_NOP;
      resp_valid_q  <= 1'b0;
      resp_op_q     <= OP_NOP;
      resp_data_q   <= '0;
      resp_status_q <= ST_OK;
      ok_cnt_q      <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      lcnt_q        <= lcnt_d;
      work_q        <= work_d;
      tbl_op_q      <= tbl_op_d;
      resp_valid_q  <= resp_valid_d;
      resp_op_q     <= resp_op_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      ok_cnt_q      <= ok_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign cmd_ready_o   = !fifo_full;
  assign tbl_key_o     = KEY_WIDTH'(work_q.key);
  assign tbl_data_o    = DATA_WIDTH'(work_q.data);
  assign tbl_op_o      = tbl_op_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_op_o     = resp_op_q;
  assign resp_data_o   = resp_data_q;
  assign resp_status_o = resp_status_q;
  assign busy_o        = (state_q != S_IDLE) || !fifo_empty;
  assign ok_cnt_o      = ok_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_hash_cmd_issuer.sv
// Bench for hash_cmd_issuer: a key-indexed controller stub, a response
// scoreboard fed by a rule-level model, vector table, corner sequences, random.
module tb_hash_cmd_issuer;
  import hash_pkg::*;

  localparam int unsigned CW      = 3;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk, reset;
  logic          cmd_valid_i, cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [1:0]    cmd_key_i;
  logic [31:0]   cmd_data_i;
  logic [1:0]    tbl_key_o;
  logic [31:0]   tbl_data_o;
  logic [1:0]    tbl_op_o;
  logic [31:0]   tbl_read_data_i;
  logic          tbl_no_del_target_i, tbl_no_write_space_i;
  logic          tbl_no_elem_found_i, tbl_key_present_i;
  logic          resp_valid_o, resp_ready_i;
  logic [1:0]    resp_op_o;
  logic [31:0]   resp_data_o;
  logic [2:0]    resp_status_o;
  logic          busy_o;
  logic [CW-1:0] ok_cnt_o, err_cnt_o;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  st;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  key;
    logic [31:0] data;
    logic [3:0]  flags;   // {no_del_target, no_write_space, key_present, no_elem_found}
    logic [31:0] rdata;
    logic [2:0]  st;
    logic [31:0] exp_data;
  } vec_t;

  // Controller stub: flags and read data are a fixed function of the key.
  logic [31:0] rdata_tbl [4];
  logic [3:0]  flags_tbl [4];
  assign tbl_read_data_i      = rdata_tbl[tbl_key_o];
  assign tbl_no_elem_found_i  = flags_tbl[tbl_key_o][0];
  assign tbl_key_present_i    = flags_tbl[tbl_key_o][1];
  assign tbl_no_write_space_i = flags_tbl[tbl_key_o][2];
  assign tbl_no_del_target_i  = flags_tbl[tbl_key_o][3];

  hash_cmd_issuer #(
    .KEY_WIDTH(2), .DATA_WIDTH(32), .LOOKUP_LATENCY(1), .FIFO_DEPTH(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_key_i(cmd_key_i), .cmd_data_i(cmd_data_i),
    .tbl_key_o(tbl_key_o), .tbl_data_o(tbl_data_o), .tbl_op_o(tbl_op_o),
    .tbl_read_data_i(tbl_read_data_i),
    .tbl_no_del_target_i(tbl_no_del_target_i), .tbl_no_write_space_i(tbl_no_write_space_i),
    .tbl_no_elem_found_i(tbl_no_elem_found_i), .tbl_key_present_i(tbl_key_present_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_op_o(resp_op_o),
    .resp_data_o(resp_data_o), .resp_status_o(resp_status_o), .busy_o(busy_o),
    .ok_cnt_o(ok_cnt_o), .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks, errors, cyc, pulses, n_done, ok_m, err_m;
  resp_t exp_q[$];
  resp_t act_q[$];
  int    resp_cyc[$];
  vec_t  vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected response straight from the op/flag rules.
  function automatic resp_t model(input logic [1:0] op, input logic [1:0] key);
    resp_t      r;
    logic [3:0] f;
    f      = flags_tbl[key];
    r.op   = op;
    r.st   = 3'd0;
    r.data = 32'd0;
    if (op == OP_READ) begin
      if (f[0]) r.st = 3'd1;
      else      r.data = rdata_tbl[key];
    end else if (op == OP_WRITE) begin
      if (f[1])      r.st = 3'd2;
      else if (f[2]) r.st = 3'd3;
    end else if (op == OP_DELETE) begin
      if (f[3]) r.st = 3'd4;
    end
    return r;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    resp_t e, a;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      ok_m  = 0;
      err_m = 0;
    end else begin
      if (cmd_valid_i && cmd_ready_o && (cmd_op_i != OP_NOP))
        exp_q.push_back(model(cmd_op_i, cmd_key_i));
      if (tbl_op_o != OP_NOP) pulses++;
      if (resp_valid_o && resp_ready_i) begin
        a.op = resp_op_o; a.st = resp_status_o; a.data = resp_data_o;
        act_q.push_back(a);
        resp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_resp", 32'(resp_op_o), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          n_done++;
          chk("sb_op", 32'(a.op), 32'(e.op));
          chk("sb_status", 32'(a.st), 32'(e.st));
          chk("sb_data", a.data, e.data);
          if (e.st == 3'd0) begin
            if (ok_m < CNT_MAX) ok_m++;
          end else begin
            if (err_m < CNT_MAX) err_m++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [1:0] key, input logic [31:0] data);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_key_i   = key;
    cmd_data_i  = data;
  endtask

  initial begin
    int to;
    checks = 0; errors = 0; cyc = 0; pulses = 0; n_done = 0; ok_m = 0; err_m = 0;
    for (int k = 0; k < 4; k++) begin
      rdata_tbl[k] = 32'h0;
      flags_tbl[k] = 4'h0;
    end
    reset = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_key_i = 2'd0;
    cmd_data_i = 32'h0; resp_ready_i = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_tbl_op", 32'(tbl_op_o), 32'd0);
    chk("rst_tbl_key", 32'(tbl_key_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ok_cnt", 32'(ok_cnt_o), 32'd0);

    // Vector table: one command at a time, fixed L=1 timing.
    vecs[0] = '{OP_WRITE,  2'd2, 32'hDEADBEEF, 4'b0000, 32'h00000000, 3'd0, 32'h00000000};
    vecs[1] = '{OP_READ,   2'd2, 32'h00000000, 4'b0001, 32'h12345678, 3'd1, 32'h00000000};
    vecs[2] = '{OP_WRITE,  2'd1, 32'h11111111, 4'b0110, 32'h00000000, 3'd2, 32'h00000000};
    vecs[3] = '{OP_WRITE,  2'd3, 32'h22222222, 4'b0100, 32'h00000000, 3'd3, 32'h00000000};
    vecs[4] = '{OP_DELETE, 2'd0, 32'h00000000, 4'b1000, 32'h00000000, 3'd4, 32'h00000000};
    vecs[5] = '{OP_READ,   2'd1, 32'h00000000, 4'b1110, 32'hCAFEF00D, 3'd0, 32'hCAFEF00D};
    vecs[6] = '{OP_DELETE, 2'd3, 32'h00000000, 4'b0111, 32'h00000000, 3'd0, 32'h00000000};
    vecs[7] = '{OP_WRITE,  2'd0, 32'h5A5A5A5A, 4'b1001, 32'hFFFFFFFF, 3'd0, 32'h00000000};
    for (int i = 0; i < 8; i++) begin
      flags_tbl[vecs[i].key] = vecs[i].flags;
      rdata_tbl[vecs[i].key] = vecs[i].rdata;
      pulses = 0;
      drive_cmd(vecs[i].op, vecs[i].key, vecs[i].data);
      tick();                                  // E0: accepted
      cmd_valid_i = 1'b0;
      tick();                                  // E1: LOOKUP
      chk("v_lookup_op", 32'(tbl_op_o), 32'd0);
      chk("v_lookup_key", 32'(tbl_key_o), 32'(vecs[i].key));
      tick();                                  // E2: EXEC
      chk("v_exec_op", 32'(tbl_op_o), 32'(vecs[i].op));
      chk("v_exec_data", tbl_data_o, vecs[i].data);
      tick();                                  // E3: RESP
      chk("v_resp_valid", 32'(resp_valid_o), 32'd1);
      chk("v_resp_tbl_op", 32'(tbl_op_o), 32'd0);
      chk("v_resp_op", 32'(resp_op_o), 32'(vecs[i].op));
      chk("v_resp_status", 32'(resp_status_o), 32'(vecs[i].st));
      chk("v_resp_data", resp_data_o, vecs[i].exp_data);
      resp_ready_i = 1'b1;
      tick();
      resp_ready_i = 1'b0;
      chk("v_resp_drop", 32'(resp_valid_o), 32'd0);
      chk("v_busy_idle", 32'(busy_o), 32'd0);
      chk("v_pulses", 32'(pulses), 32'd1);
      chk("v_ok_cnt", 32'(ok_cnt_o), 32'(ok_m));
      chk("v_err_cnt", 32'(err_cnt_o), 32'(err_m));
    end
    chk("v_ok_total", 32'(ok_cnt_o), 32'd4);
    chk("v_err_total", 32'(err_cnt_o), 32'd4);

    // FIFO full with the response stalled, then drain at L+2 spacing.
    for (int k = 0; k < 4; k++) flags_tbl[k] = 4'h0;
    rdata_tbl[0] = 32'hA0A0A0A0; rdata_tbl[3] = 32'hB3B3B3B3;
    resp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("full_ready_before_push", 32'(cmd_ready_o), 32'd1);
      case (i)
        0: drive_cmd(OP_READ,   2'd0, 32'h0);
        1: drive_cmd(OP_WRITE,  2'd1, 32'h1001);
        2: drive_cmd(OP_DELETE, 2'd2, 32'h0);
        3: drive_cmd(OP_READ,   2'd3, 32'h0);
        default: drive_cmd(OP_WRITE, 2'd0, 32'h5005);
      endcase
      tick();
    end
    cmd_valid_i = 1'b0;
    chk("full_ready_low", 32'(cmd_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(resp_valid_o), 32'd1);
      chk("hold_op", 32'(resp_op_o), 32'(OP_READ));
      chk("hold_data", resp_data_o, 32'hA0A0A0A0);
      chk("hold_ready_low", 32'(cmd_ready_o), 32'd0);
      tick();
    end
    resp_cyc.delete();
    resp_ready_i = 1'b1;
    to = 0;
    while (resp_cyc.size() < 5 && to < 60) begin tick(); to++; end
    chk("drain_count", 32'(resp_cyc.size()), 32'd5);
    if (resp_cyc.size() == 5)
      for (int i = 1; i < 5; i++)
        chk("drain_spacing", 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd3);
    chk("ok_cnt_saturated", 32'(ok_cnt_o), 32'(CNT_MAX));
    chk("ok_cnt_model", 32'(ok_cnt_o), 32'(ok_m));

    // Nop between a read and a failing delete.
    tick();
    flags_tbl[2] = 4'b1000;
    rdata_tbl[1] = 32'h0BADF00D;
    pulses = 0;
    act_q.delete();
    drive_cmd(OP_READ,   2'd1, 32'h0); tick();
    drive_cmd(OP_NOP,    2'd3, 32'h0); tick();
    drive_cmd(OP_DELETE, 2'd2, 32'h0); tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("nop_pulses", 32'(pulses), 32'd2);
    chk("nop_resp_count", 32'(act_q.size()), 32'd2);
    if (act_q.size() == 2) begin
      chk("nop_first_op", 32'(act_q[0].op), 32'(OP_READ));
      chk("nop_first_data", act_q[0].data, 32'h0BADF00D);
      chk("nop_second_op", 32'(act_q[1].op), 32'(OP_DELETE));
      chk("nop_second_status", 32'(act_q[1].st), 32'd4);
    end

    // Reset during LOOKUP with two commands queued.
    flags_tbl[2] = 4'b0000;
    resp_ready_i = 1'b0;
    drive_cmd(OP_WRITE, 2'd1, 32'h1); tick();
    drive_cmd(OP_WRITE, 2'd2, 32'h2); tick();
    drive_cmd(OP_WRITE, 2'd3, 32'h3); tick();
    drive_cmd(OP_WRITE, 2'd0, 32'h4); tick();
    cmd_valid_i = 1'b0;
    chk("rstseq_first_resp", 32'(resp_valid_o), 32'd1);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("rstseq_in_lookup_key", 32'(tbl_key_o), 32'd2);
    chk("rstseq_in_lookup_busy", 32'(busy_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstseq_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rstseq_tbl_key", 32'(tbl_key_o), 32'd0);
    chk("rstseq_tbl_data", tbl_data_o, 32'd0);
    chk("rstseq_tbl_op", 32'(tbl_op_o), 32'd0);
    chk("rstseq_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rstseq_resp_data", resp_data_o, 32'd0);
    chk("rstseq_busy", 32'(busy_o), 32'd0);
    chk("rstseq_ok_cnt", 32'(ok_cnt_o), 32'd0);
    chk("rstseq_err_cnt", 32'(err_cnt_o), 32'd0);
    pulses = 0;
    act_q.delete();
    resp_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("rstseq_no_resp", 32'(act_q.size()), 32'd0);
    chk("rstseq_no_pulse", 32'(pulses), 32'd0);

    // Random traffic against the scoreboard.
    for (int seg = 0; seg < 2; seg++) begin
      for (int k = 0; k < 4; k++) begin
        rdata_tbl[k] = $urandom;
        flags_tbl[k] = 4'($urandom);
      end
      pulses = 0;
      n_done = 0;
      for (int c = 0; c < 300; c++) begin
        cmd_valid_i  = ($urandom_range(0, 9) < 6);
        cmd_op_i     = 2'($urandom);
        cmd_key_i    = 2'($urandom);
        cmd_data_i   = $urandom;
        resp_ready_i = ($urandom_range(0, 9) < 7);
        tick();
      end
      cmd_valid_i  = 1'b0;
      resp_ready_i = 1'b1;
      to = 0;
      while ((exp_q.size() != 0 || busy_o) && to < 200) begin tick(); to++; end
      chk("rand_drain_timeout", 32'(to < 200), 32'd1);
      chk("rand_pulses", 32'(pulses), 32'(n_done));
      chk("rand_ok_cnt", 32'(ok_cnt_o), 32'(ok_m));
      chk("rand_err_cnt", 32'(err_cnt_o), 32'(err_m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_cmd_issuer.md
# hash_cmd_issuer

Host-side command front-end for the multi-table hash engine with CAM overflow. Accepts read/write/delete commands over a valid/ready stream, buffers them, and sequences each one into the hash table controller as a lookup phase followed by a single execute cycle. It captures the returned data and error flags into a response stream and keeps saturating success and error counters.

## Interface
Parameters:
- KEY_WIDTH, 2: key width.
- DATA_WIDTH, 32: data width.
- LOOKUP_LATENCY, 1: cycles from key presentation until the table read-outs and flags are valid. Must be ≥1.
- FIFO_DEPTH, 4: command buffer entries. Must be a power of 2, ≥2.
- CNT_WIDTH, 16: statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  = !fifo_full.
- cmd_op_i  in  2  00 nop, 01 read, 10 write, 11 delete.
- cmd_key_i  in  KEY_WIDTH  command key.
- cmd_data_i  in  DATA_WIDTH  write data.
- tbl_key_o  out  KEY_WIDTH  key to the hash controller and hash units.
- tbl_data_o  out  DATA_WIDTH  data to the controller.
- tbl_op_o  out  2  controller delete_write_read; non-zero only in EXEC.
- tbl_read_data_i  in  DATA_WIDTH  controller read data.
- tbl_no_del_target_i, tbl_no_write_space_i, tbl_no_elem_found_i, tbl_key_present_i  in  1 each  controller error flags.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  response consumed.
- resp_op_o  out  2  op of the completed command.
- resp_data_o  out  DATA_WIDTH  read data; 0 for write/delete.
- resp_status_o  out  3  0 OK, 1 NOT_FOUND, 2 KEY_PRESENT, 3 NO_SPACE, 4 NO_DEL_TARGET.
- busy_o  out  1  state != IDLE or FIFO non-empty.
- ok_cnt_o, err_cnt_o  out  CNT_WIDTH  saturating completion counters.

## Operation
- Push into the FIFO when cmd_valid_i && cmd_ready_o. Nop commands are pushed, and on pop are discarded in one cycle with no table activity and no response.
- States:
  - IDLE: FIFO non-empty → pop into the working register. Op ≠ 00 → LOOKUP with lcnt = LOOKUP_LATENCY−1. Op = 00 → stay in IDLE.
  - LOOKUP: tbl_key_o/tbl_data_o = working command, tbl_op_o = 00. lcnt = 0 → EXEC, else decrement.
  - EXEC: exactly one cycle. tbl_op_o = working op. Sample flags and read data into the response registers → RESP.
  - RESP: resp_valid_o = 1; all response outputs held stable until resp_ready_i. On handshake:
    - FIFO non-empty with a non-nop head → pop directly into LOOKUP.
    - Nop head → pop it and go to IDLE.
    - Otherwise → IDLE.
- Status priority in EXEC, keyed to the op:
  - read: no_elem_found → 1.
  - write: key_present → 2, else no_write_space → 3.
  - delete: no_del_target → 4.
  - Otherwise 0.
- Counters: on entry to RESP, increment ok_cnt if status = 0, else err_cnt. Both saturate at all-ones and do not wrap.
- tbl_key_o/tbl_data_o hold the last issued command while in IDLE and RESP.

## Timing
- Reset: state IDLE, FIFO empty, cmd_ready_o = 1, all other outputs 0, counters 0. A reset mid-command aborts it; no response is produced and the FIFO contents are dropped.
- Latency: command accepted at edge E0 → LOOKUP from E1 → EXEC from E1+L → resp_valid_o from E2+L. With L=1, resp_valid_o is high after edge 3.
- Back-to-back: the next LOOKUP starts at the RESP handshake edge. Throughput is one command per L+2 cycles with resp_ready_i tied high.
- FIFO full: cmd_ready_o = 0, with no same-cycle push-through on a pop. A push and a pop in the same cycle are both honoured when not full.
- tbl_key_o is stable for all L+1 cycles of LOOKUP and EXEC, and tbl_op_o ≠ 00 for exactly one cycle per command.

## Structure
- hash_pkg:
  - op localparams OP_NOP/READ/WRITE/DELETE, shared with the hash controller.
  - status enum (3-bit).
  - issuer state enum.
  - cmd struct {op, key, data}.
- Sub-module hash_cmd_fifo: synchronous FIFO, parameterised width/depth, outputs full/empty, registered read data available in the pop cycle (first-word fall-through).
- Issuer FSM, response registers and counters live in hash_cmd_issuer.

## Test plan
- Write key 2, data 0xDEADBEEF, all flags 0, L=1:
  - tbl_op_o = 10 for one cycle after edge 2.
  - resp_status_o = 0 after edge 3; ok_cnt = 1.
- Read with tbl_no_elem_found_i = 1 in EXEC → resp_status_o = 1, resp_data_o = 0, err_cnt = 1.
- Write with key_present and no_write_space both 1 → status 2, showing priority.
- Push 5 commands with resp_ready_i = 0:
  - cmd_ready_o drops after 4 buffered entries.
  - The first response is held stable; releasing resp_ready_i drains all 5 responses in order, each L+2 cycles apart.
- Nop interleaved between read and delete:
  - No tbl_op_o pulse and no response for the nop.
  - Delete with no_del_target → status 4.
- Assert reset during LOOKUP with 2 commands queued:
  - The next cycle shows all outputs at reset values and cmd_ready_o = 1.
  - No response is ever produced for the aborted commands.
